sync_fifo_ext: RTL and testbench
================================

Name: sync_fifo_ext

Overview:
Second-generation single-clock FIFO for the USB interface datapath. Supports any depth, not only powers of two. Adds runtime-programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. A FWFT parameter selects between first-word-fall-through output and registered-read output.

Parameters:
DATA_WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2, any integer)
LOG2DEPTH, 4, ceil(log2(DEPTH)); pointer width; count width is LOG2DEPTH+1
FWFT, 1, 1 = head word visible on o_data while non-empty; 0 = registered read, data one cycle after the read strobe

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
i_flush  in  1  synchronous flush: empties FIFO and clears error flags
i_clear_err  in  1  synchronous clear of o_overflow/o_underflow
i_data  in  DATA_WIDTH  write data
i_write_enable  in  1  write request
i_almost_full_th  in  LOG2DEPTH+1  almost-full threshold
i_almost_empty_th  in  LOG2DEPTH+1  almost-empty threshold
i_read_enable  in  1  read request
o_data  out  DATA_WIDTH  read data
o_valid  out  1  o_data valid qualifier
o_full  out  1  count == DEPTH
o_almost_full  out  1  count >= i_almost_full_th
o_empty  out  1  count == 0
o_almost_empty  out  1  count <= i_almost_empty_th
o_count  out  LOG2DEPTH+1  current occupancy
o_overflow  out  1  sticky: write dropped because FIFO was full
o_underflow  out  1  sticky: read attempted while FIFO was empty

Behaviour:
- Reset (async, reset_n=0): read pointer, write pointer and count = 0; o_overflow = o_underflow = 0; o_valid = 0; o_data = 0. Status outputs follow from count = 0: o_empty=1, o_full=0; o_almost_empty=1 if i_almost_empty_th>=0, i.e. always. Storage array is not reset.
- Dequeue: deq = i_read_enable & !o_empty.
- Enqueue: enq = i_write_enable & (!o_full | deq). A write to a full FIFO succeeds if a read happens in the same cycle.
- Pointers: each advances by 1 on its event and wraps from DEPTH-1 to 0, so non-power-of-2 DEPTH is legal. Write stores i_data at the write pointer on enq.
- Count update:
  - +1 on enq & !deq
  - -1 on deq & !enq
  - unchanged otherwise, including a simultaneous enq+deq
  - never exceeds DEPTH, never goes below 0
- Status outputs are combinational from the registered count and the threshold inputs, compared unsigned. Threshold 0 for almost_full makes o_almost_full constantly 1; that is legal.
- Overflow: i_write_enable & o_full & !deq sets o_overflow; the data is dropped and no state changes.
- Underflow: i_read_enable & o_empty sets o_underflow; no state changes.
- Error flags stay set until i_clear_err or i_flush. If set and clear occur in the same cycle, the clear wins.
- FWFT=1:
  - o_data = storage[read pointer] when !o_empty, else 0.
  - o_valid = !o_empty.
  - The word is consumed on the clock edge where deq=1.
- FWFT=0:
  - On deq, o_data <= storage[read pointer] and o_valid <= 1 on the next edge.
  - o_valid is a 1-cycle pulse per read. o_data holds its last value while o_valid=0.
  - Read latency is 1 cycle.
- Flush has priority over everything:
  - pointers, count, o_overflow, o_underflow and o_valid go to 0; o_data goes to 0 in FWFT=0 mode.
  - A write or read in the same cycle is ignored and does not raise error flags.
- Empty FIFO with simultaneous write and read: the read is an underflow (flag set) and the write is accepted, giving count=1. There is no bypass of an empty FIFO.
- Mid-operation reset: immediate asynchronous return to the reset values above. The contents are logically discarded.

Test Plan:
- Fill/overflow, DEPTH=16, FWFT=1: write 0x00..0x10 (17 words) with no reads -> o_full=1 after 16 writes, o_count=16, o_overflow=1 after the 17th; drain gives 0x00..0x0F in order, then o_empty=1.
- Full simultaneous read/write: at count=16, assert write(0xAA) and read in one cycle -> count stays 16, o_overflow stays 0, 0xAA is read last after 15 older words.
- Thresholds: i_almost_full_th=12, i_almost_empty_th=3; write 12 words -> o_almost_full rises when count reaches 12; read 9 -> o_almost_empty rises at count 3; underflow read at count 0 -> o_underflow=1, cleared by a 1-cycle i_clear_err.
- Flush mid-stream: count=7, pulse i_flush together with a write and a read -> next cycle count=0, o_empty=1, both flags 0; the following write/read returns the new word.
- FWFT=0 latency: write 0x11, 0x22; read pulse on cycle N -> o_valid=1 with o_data=0x11 on cycle N+1; o_valid=0 on N+2 with o_data still 0x11.
- Non-power-of-2 wrap, DEPTH=12, LOG2DEPTH=4: run 40 interleaved random writes/reads -> output order matches a reference queue, pointers wrap 11->0, o_full asserts at count=12.

Source files
------------

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO, any depth, programmable thresholds,
// occupancy count, sticky error flags, FWFT or registered read.
module sync_fifo_ext #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int LOG2DEPTH  = 4,
   parameter bit FWFT       = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_flush,
   input  logic                  i_clear_err,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_write_enable,
   input  logic [LOG2DEPTH:0]    i_almost_full_th,
   input  logic [LOG2DEPTH:0]    i_almost_empty_th,
   input  logic                  i_read_enable,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_full,
   output logic                  o_almost_full,
   output logic                  o_empty,
   output logic                  o_almost_empty,
   output logic [LOG2DEPTH:0]    o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int CW = LOG2DEPTH + 1;
   localparam logic [LOG2DEPTH-1:0] LAST  = LOG2DEPTH'(DEPTH - 1);
   localparam logic [CW-1:0]        FULLC = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [LOG2DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LOG2DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  empty, full, deq, enq;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULLC);
   // Flush masks both events so nothing moves in a flush cycle.
   assign deq = i_read_enable & ~empty & ~i_flush;
   assign enq = i_write_enable & (~full | deq) & ~i_flush;

   assign o_empty        = empty;
   assign o_full         = full;
   assign o_count        = count_q;
   assign o_almost_full  = (count_q >= i_almost_full_th);
   assign o_almost_empty = (count_q <= i_almost_empty_th);
   assign o_overflow     = ovf_q;
   assign o_underflow    = unf_q;

   // Next-state for pointers, occupancy and error flags.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (deq)
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + LOG2DEPTH'(1);
         if (enq)
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + LOG2DEPTH'(1);
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (i_clear_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end else begin
            if (i_write_enable & full & ~deq) ovf_d = 1'b1;
            if (i_read_enable & empty)        unf_d = 1'b1;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage write; contents are not reset.
   always_ff @(posedge clk) begin
      if (enq) mem_q[wr_ptr_q] <= i_data;
   end

   if (FWFT) begin : g_fwft
      assign o_data  = empty ? '0 : mem_q[rd_ptr_q];
      assign o_valid = ~empty;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      // Registered read: one-cycle valid pulse, data held otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else if (i_flush) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= deq;
            if (deq) data_q <= mem_q[rd_ptr_q];
         end
      end

      assign o_data  = data_q;
      assign o_valid = valid_q;
   end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: DEPTH=16 FWFT=1 and
// DEPTH=12 FWFT=0 instances exercised in sequence.
module tb_sync_fifo_ext;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush, clr;
   logic [31:0] data;
   logic [4:0]  af_th, ae_th;
   logic        a_wr, a_rd, b_wr, b_rd;

   logic [31:0] a_data, b_data;
   logic        a_valid, a_full, a_af, a_empty, a_ae, a_ov, a_un;
   logic        b_valid, b_full, b_af, b_empty, b_ae, b_ov, b_un;
   logic [4:0]  a_count, b_count;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sync_fifo_ext #(
      .DATA_WIDTH(32), .DEPTH(16), .LOG2DEPTH(4), .FWFT(1'b1)
   ) u_a (
      .clk(clk), .reset_n(reset_n), .i_flush(flush),
      .i_clear_err(clr), .i_data(data), .i_write_enable(a_wr),
      .i_almost_full_th(af_th), .i_almost_empty_th(ae_th),
      .i_read_enable(a_rd), .o_data(a_data), .o_valid(a_valid),
      .o_full(a_full), .o_almost_full(a_af), .o_empty(a_empty),
      .o_almost_empty(a_ae), .o_count(a_count),
      .o_overflow(a_ov), .o_underflow(a_un)
   );

   sync_fifo_ext #(
      .DATA_WIDTH(32), .DEPTH(12), .LOG2DEPTH(4), .FWFT(1'b0)
   ) u_b (
      .clk(clk), .reset_n(reset_n), .i_flush(flush),
      .i_clear_err(clr), .i_data(data), .i_write_enable(b_wr),
      .i_almost_full_th(af_th), .i_almost_empty_th(ae_th),
      .i_read_enable(b_rd), .o_data(b_data), .o_valid(b_valid),
      .o_full(b_full), .o_almost_full(b_af), .o_empty(b_empty),
      .o_almost_empty(b_ae), .o_count(b_count),
      .o_overflow(b_ov), .o_underflow(b_un)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] q[$];
   logic [31:0] expd;
   logic        dq, eq, ov_m, un_m;

   initial begin
      reset_n = 1'b0;
      flush = 1'b0; clr = 1'b0; data = '0;
      af_th = 5'd12; ae_th = 5'd3;
      a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
      #12;
      chk("rst_count", a_count, 0);
      chk("rst_empty", a_empty, 1);
      chk("rst_full", a_full, 0);
      chk("rst_ae", a_ae, 1);
      chk("rst_af", a_af, 0);
      chk("rst_valid", a_valid, 0);
      chk("rst_data", a_data, 0);
      chk("rst_ov", a_ov, 0);
      chk("rst_un", a_un, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_b_data", b_data, 0);
      reset_n = 1'b1;
      tick();

      // fill 17 words, last one overflows
      for (int i = 0; i < 17; i++) begin
         data = 32'(i); a_wr = 1'b1;
         tick();
         chk("fill_count", a_count, (i < 16) ? i + 1 : 16);
         chk("fill_af", a_af, i >= 11);
         chk("fill_full", a_full, i >= 15);
         chk("fill_ov", a_ov, i == 16);
      end
      a_wr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("drain_data", a_data, i);
         chk("drain_valid", a_valid, 1);
         a_rd = 1'b1;
         tick();
      end
      a_rd = 1'b0;
      chk("drain_empty", a_empty, 1);
      chk("drain_count", a_count, 0);
      chk("drain_zero", a_data, 0);
      chk("ov_sticky", a_ov, 1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("ov_clr", a_ov, 0);

      // full + simultaneous read/write
      for (int i = 0; i < 16; i++) begin
         data = 32'h100 + 32'(i); a_wr = 1'b1;
         tick();
      end
      chk("full16", a_count, 16);
      data = 32'hAA; a_rd = 1'b1;
      tick();
      a_wr = 1'b0; a_rd = 1'b0;
      chk("rw_count", a_count, 16);
      chk("rw_ov", a_ov, 0);
      chk("rw_full", a_full, 1);
      for (int i = 0; i < 16; i++) begin
         chk("rw_data", a_data, (i < 15) ? 32'h101 + i : 32'hAA);
         a_rd = 1'b1;
         tick();
      end
      a_rd = 1'b0;
      chk("rw_empty", a_empty, 1);

      // thresholds
      for (int i = 0; i < 12; i++) begin
         data = 32'h200 + 32'(i); a_wr = 1'b1;
         tick();
         chk("th_af", a_af, i >= 11);
      end
      a_wr = 1'b0;
      for (int i = 0; i < 9; i++) begin
         a_rd = 1'b1;
         tick();
         chk("th_ae", a_ae, i >= 8);
      end
      chk("th_data", a_data, 32'h209);
      tick(); tick(); tick();
      a_rd = 1'b0;
      chk("th_count0", a_count, 0);
      a_rd = 1'b1; tick(); a_rd = 1'b0;
      chk("un_set", a_un, 1);
      chk("un_count", a_count, 0);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("un_clr", a_un, 0);
      a_rd = 1'b1; clr = 1'b1; tick();
      a_rd = 1'b0; clr = 1'b0;
      chk("un_clr_wins", a_un, 0);

      // flush mid-stream with write+read, flags cleared
      a_rd = 1'b1; tick(); a_rd = 1'b0;
      chk("un_pre_flush", a_un, 1);
      for (int i = 0; i < 7; i++) begin
         data = 32'h300 + 32'(i); a_wr = 1'b1;
         tick();
      end
      chk("fl_count7", a_count, 7);
      data = 32'h55; a_rd = 1'b1; flush = 1'b1;
      tick();
      a_wr = 1'b0; a_rd = 1'b0; flush = 1'b0;
      chk("fl_count", a_count, 0);
      chk("fl_empty", a_empty, 1);
      chk("fl_ov", a_ov, 0);
      chk("fl_un", a_un, 0);
      chk("fl_valid", a_valid, 0);
      data = 32'h77; a_wr = 1'b1; tick(); a_wr = 1'b0;
      chk("fl_new", a_data, 32'h77);
      chk("fl_new_cnt", a_count, 1);
      a_rd = 1'b1; tick(); a_rd = 1'b0;
      chk("fl_new_empty", a_empty, 1);

      // empty FIFO with write+read: underflow, write accepted
      data = 32'h99; a_wr = 1'b1; a_rd = 1'b1;
      tick();
      a_wr = 1'b0; a_rd = 1'b0;
      chk("er_count", a_count, 1);
      chk("er_un", a_un, 1);
      chk("er_data", a_data, 32'h99);

      // asynchronous reset mid-operation
      #2; reset_n = 1'b0; #1;
      chk("ar_count", a_count, 0);
      chk("ar_empty", a_empty, 1);
      chk("ar_un", a_un, 0);
      chk("ar_valid", a_valid, 0);
      @(negedge clk); reset_n = 1'b1;
      tick();

      // registered read latency
      data = 32'h11; b_wr = 1'b1; tick();
      data = 32'h22; tick();
      b_wr = 1'b0;
      chk("b_idle_valid", b_valid, 0);
      b_rd = 1'b1; tick(); b_rd = 1'b0;
      chk("b_n1_valid", b_valid, 1);
      chk("b_n1_data", b_data, 32'h11);
      tick();
      chk("b_n2_valid", b_valid, 0);
      chk("b_n2_data", b_data, 32'h11);
      b_rd = 1'b1; tick(); b_rd = 1'b0;
      chk("b_rd2_data", b_data, 32'h22);
      tick();
      chk("b_empty", b_empty, 1);

      // DEPTH=12 interleaved traffic against a reference queue
      ov_m = 1'b0; un_m = 1'b0; expd = '0;
      for (int s = 0; s < 40; s++) begin
         b_wr = (s < 14) ? 1'b1 : 1'($urandom_range(0, 1));
         b_rd = (s < 14) ? 1'b0 : ($urandom_range(0, 2) != 0);
         data = $urandom;
         dq = b_rd && (q.size() > 0);
         eq = b_wr && ((q.size() < 12) || dq);
         if (b_wr && q.size() == 12 && !dq) ov_m = 1'b1;
         if (b_rd && q.size() == 0) un_m = 1'b1;
         if (dq) expd = q.pop_front();
         if (eq) q.push_back(data);
         tick();
         chk("w_count", b_count, 64'(q.size()));
         chk("w_full", b_full, q.size() == 12);
         chk("w_valid", b_valid, dq);
         if (dq) chk("w_data", b_data, expd);
         chk("w_ov", b_ov, ov_m);
         chk("w_un", b_un, un_m);
      end
      b_wr = 1'b0; b_rd = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
